// File: rtl/emu_io_bank.sv
// Parametrised FPGA pad bank: per-channel mode mux, input synchroniser,
// glitch filter, edge pulses and saturating rising-edge counter.

module emu_io_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_out,
  input  logic                    core_oeb,
  input  logic                    pad_in,
  input  logic                    we,
  input  logic [FILT_W+1:0]       wdata,
  output logic                    core_in,
  output logic                    pad_out,
  output logic                    pad_tri,
  output logic                    rise,
  output logic                    fall,
  output logic [CNT_W+FILT_W+1:0] rdata
);
  localparam logic [1:0] PASS = 2'd0, LOOP = 2'd1, FLOW = 2'd3;

  typedef struct packed {
    logic [FILT_W-1:0] flen;
    logic [1:0]        mode;
  } cfg_t;

  cfg_t                   cfg;
  logic [SYNC_STAGES-1:0] sync;
  logic                   f, init;
  logic [FILT_W-1:0]      c;
  logic [CNT_W-1:0]       cnt;
  logic                   s, accept;

  assign s      = sync[SYNC_STAGES-1];
  assign accept = (s != f) && (c == cfg.flen) && (cfg.mode != FLOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg  <= '0;
      sync <= '0;
      f    <= 1'b0;
      c    <= '0;
      init <= 1'b0;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], (cfg.mode == LOOP) ? core_out : pad_in};
      rise <= accept & init & s;
      fall <= accept & init & ~s;
      // FORCE_LOW freezes the filter entirely so no edges leak out
      if (cfg.mode != FLOW) begin
        if (s == f) c <= '0;
        else if (accept) begin
          f    <= s;
          c    <= '0;
          init <= 1'b1;
        end else c <= c + 1'b1;
      end
      if (rise && cnt != '1) cnt <= cnt + 1'b1;
      // a config write overrides both the stability count and the edge count
      if (we) begin
        cfg <= cfg_t'(wdata);
        c   <= '0;
        cnt <= '0;
      end
    end
  end

  always_comb begin
    pad_out = 1'b0;
    pad_tri = 1'b1;
    if (!rst) begin
      case (cfg.mode)
        PASS: begin
          pad_out = core_out;
          pad_tri = core_oeb;
        end
        FLOW:    pad_tri = 1'b0;
        default: ;
      endcase
    end
  end

  assign core_in = f & (cfg.mode != FLOW) & ~rst;
  assign rdata   = {cnt, cfg.flen, cfg.mode};
endmodule

module emu_io_bank #(
  parameter int N_IO        = 10,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int CNT_W       = 8,
  localparam int SEL_W      = (N_IO > 1) ? $clog2(N_IO) : 1,
  localparam int RD_W       = 2 + FILT_W + CNT_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [N_IO-1:0]   core_io_out,
  input  logic [N_IO-1:0]   core_io_oeb,
  output logic [N_IO-1:0]   core_io_in,
  input  logic [N_IO-1:0]   pad_i,
  output logic [N_IO-1:0]   pad_o,
  output logic [N_IO-1:0]   pad_t,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [FILT_W+1:0] cfg_wdata,
  output logic [RD_W-1:0]   cfg_rdata,
  output logic [N_IO-1:0]   edge_rise,
  output logic [N_IO-1:0]   edge_fall
);
  logic [N_IO-1:0][RD_W-1:0] lane_rd;

  for (genvar i = 0; i < N_IO; i++) begin : g_lane
    emu_io_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_W     (FILT_W),
      .CNT_W      (CNT_W)
    ) u_lane (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .core_out(core_io_out[i]),
      .core_oeb(core_io_oeb[i]),
      .pad_in  (pad_i[i]),
      .we      (cfg_we && (int'(cfg_sel) == i)),
      .wdata   (cfg_wdata),
      .core_in (core_io_in[i]),
      .pad_out (pad_o[i]),
      .pad_tri (pad_t[i]),
      .rise    (edge_rise[i]),
      .fall    (edge_fall[i]),
      .rdata   (lane_rd[i])
    );
  end

  // out-of-range selects match no lane and read back as zero
  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < N_IO; i++)
      if (int'(cfg_sel) == i && !wb_rst_i) cfg_rdata = lane_rd[i];
  end
endmodule

// File: tb/tb_emu_io_bank.sv
// Bench for emu_io_bank: directed sequences, a pad-mapping vector table and
// randomized traffic, all checked against a behavioural channel model.

module tb_emu_io_bank;
  localparam int N = 13, SS = 2, FW = 4, CW = 8, SW = 4, RW = 2 + FW + CW;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0, rst;
  logic [N-1:0]  cout, coeb, cin, pi, po, pt, er, ef;
  logic          we;
  logic [SW-1:0] sel;
  logic [FW+1:0] wd;
  logic [RW-1:0] rd;

  always #5 clk = ~clk;

  emu_io_bank #(.N_IO(N), .SYNC_STAGES(SS), .FILT_W(FW), .CNT_W(CW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .core_io_out(cout), .core_io_oeb(coeb),
    .core_io_in(cin), .pad_i(pi), .pad_o(po), .pad_t(pt), .cfg_we(we),
    .cfg_sel(sel), .cfg_wdata(wd), .cfg_rdata(rd), .edge_rise(er), .edge_fall(ef));

  int checks = 0, errors = 0;

  // per-channel model: dly holds the samples still in flight, run counts
  // consecutive cycles where the settled sample disagrees with the filtered value
  int m_mode[N], m_flen[N], m_f[N], m_run[N], m_init[N], m_rise[N], m_fall[N], m_cnt[N];
  int m_dly[N][SS];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    for (int ch = 0; ch < N; ch++) begin
      if (rst) begin
        m_mode[ch] = 0; m_flen[ch] = 0; m_f[ch] = 0; m_run[ch] = 0;
        m_init[ch] = 0; m_rise[ch] = 0; m_fall[ch] = 0; m_cnt[ch] = 0;
        for (int k = 0; k < SS; k++) m_dly[ch][k] = 0;
      end else begin
        int s, src, old_rise;
        old_rise = m_rise[ch];
        s = m_dly[ch][SS-1];
        src = (m_mode[ch] == 1) ? int'(cout[ch]) : int'(pi[ch]);
        for (int k = SS - 1; k > 0; k--) m_dly[ch][k] = m_dly[ch][k-1];
        m_dly[ch][0] = src;
        m_rise[ch] = 0;
        m_fall[ch] = 0;
        if (m_mode[ch] != 3) begin
          if (s != m_f[ch]) begin
            m_run[ch]++;
            if (m_run[ch] > m_flen[ch]) begin
              if (m_init[ch] != 0) begin
                m_rise[ch] = s;
                m_fall[ch] = 1 - s;
              end
              m_f[ch] = s;
              m_init[ch] = 1;
              m_run[ch] = 0;
            end
          end else m_run[ch] = 0;
        end
        if (old_rise != 0 && m_cnt[ch] < CMAX) m_cnt[ch]++;
        if (we && int'(sel) == ch) begin
          m_mode[ch] = int'(wd[1:0]);
          m_flen[ch] = int'(wd[FW+1:2]);
          m_run[ch] = 0;
          m_cnt[ch] = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [N-1:0] e_cin, e_po, e_pt, e_er, e_ef;
    logic [RW-1:0] e_rd;
    for (int ch = 0; ch < N; ch++) begin
      e_cin[ch] = !rst && m_f[ch] != 0 && m_mode[ch] != 3;
      e_er[ch]  = m_rise[ch] != 0;
      e_ef[ch]  = m_fall[ch] != 0;
      if (rst || m_mode[ch] == 1 || m_mode[ch] == 2) begin
        e_pt[ch] = 1'b1; e_po[ch] = 1'b0;
      end else if (m_mode[ch] == 3) begin
        e_pt[ch] = 1'b0; e_po[ch] = 1'b0;
      end else begin
        e_pt[ch] = coeb[ch]; e_po[ch] = cout[ch];
      end
    end
    e_rd = '0;
    if (!rst && int'(sel) < N)
      e_rd = {CW'(m_cnt[sel]), FW'(m_flen[sel]), 2'(m_mode[sel])};
    chk("core_io_in", 32'(cin), 32'(e_cin));
    chk("pad_o", 32'(po), 32'(e_po));
    chk("pad_t", 32'(pt), 32'(e_pt));
    chk("edge_rise", 32'(er), 32'(e_er));
    chk("edge_fall", 32'(ef), 32'(e_ef));
    chk("cfg_rdata", 32'(rd), 32'(e_rd));
  endtask

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_update();
      check_model();
    end
  endtask

  task automatic cfg_write(int ch, int flen, int mode);
    we = 1'b1;
    sel = SW'(ch);
    wd = {FW'(flen), 2'(mode)};
    tick();
    we = 1'b0;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       oeb, out, exp_t, exp_o;
  } vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[1] = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{2'd1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[3] = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[4] = '{2'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[5] = '{2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{2'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[7] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; cout = '0; coeb = '1; pi = '0; we = 1'b0; sel = '0; wd = '0;
    tick(2);
    chk("rst_pad_t", 32'(pt), 32'({N{1'b1}}));
    chk("rst_rdata", 32'(rd), 32'(0));
    rst = 1'b0;
    tick();

    // PASS is combinational; then first acceptance on every channel is silent
    coeb[10] = 1'b0; cout[10] = 1'b1;
    #1;
    chk("pass_t10", 32'(pt[10]), 32'(0));
    chk("pass_o10", 32'(po[10]), 32'(1));
    pi = '1;
    tick(2);
    chk("init_cin_early", 32'(cin[12]), 32'(0));
    tick();
    chk("init_cin12", 32'(cin[12]), 32'(1));
    chk("init_no_rise", 32'(er), 32'(0));
    pi = '0;
    tick(3);
    chk("first_fall_all", 32'(ef), 32'({N{1'b1}}));
    tick();
    chk("fall_one_cycle", 32'(ef), 32'(0));

    // glitch filter with filt_len = 3
    cfg_write(0, 3, 0);
    pi[0] = 1'b1;
    tick(3);
    pi[0] = 1'b0;
    tick(10);
    chk("glitch_rejected", 32'(cin[0]), 32'(0));
    pi[0] = 1'b1;
    tick(4);
    pi[0] = 1'b0;
    tick();
    chk("filt_cin_t5", 32'(cin[0]), 32'(0));
    tick();
    chk("filt_cin_t6", 32'(cin[0]), 32'(1));
    chk("filt_rise_t6", 32'(er[0]), 32'(1));
    tick();
    chk("filt_rise_once", 32'(er[0]), 32'(0));
    tick(10);

    // pad mapping table on channel 3
    for (int i = 0; i < 8; i++) begin
      cfg_write(3, 0, int'(vt[i].mode));
      cout[3] = vt[i].out; coeb[3] = vt[i].oeb;
      #1;
      chk($sformatf("vec%0d_t", i), 32'(pt[3]), 32'(vt[i].exp_t));
      chk($sformatf("vec%0d_o", i), 32'(po[3]), 32'(vt[i].exp_o));
    end
    cfg_write(3, 0, 0);
    tick(4);

    // loopback on channel 5
    cfg_write(5, 0, 1);
    chk("loop_t5", 32'(pt[5]), 32'(1));
    cout[5] = 1'b1; coeb[5] = 1'b0;
    tick(2);
    chk("loop_cin_early", 32'(cin[5]), 32'(0));
    tick();
    chk("loop_cin5", 32'(cin[5]), 32'(1));
    chk("loop_t5_hold", 32'(pt[5]), 32'(1));

    // force low on channel 6, force in on channel 7
    cfg_write(6, 0, 3);
    cout[6] = 1'b1; coeb[6] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pi[6] = ~pi[6];
      tick(2);
      chk("flow_cin6", 32'(cin[6]), 32'(0));
      chk("flow_edges", 32'({er[6], ef[6]}), 32'(0));
    end
    chk("flow_t6", 32'(pt[6]), 32'(0));
    chk("flow_o6", 32'(po[6]), 32'(0));
    cfg_write(7, 0, 2);
    coeb[7] = 1'b0; cout[7] = 1'b1;
    #1;
    chk("fin_t7", 32'(pt[7]), 32'(1));

    // saturating counter on channel 8
    for (int i = 0; i < 300; i++) begin
      pi[8] = 1'b1; tick(2);
      pi[8] = 1'b0; tick(2);
    end
    tick(5);
    sel = 4'd8;
    #1;
    chk("cnt_sat", 32'(rd[RW-1:2+FW]), 32'(CMAX));
    cfg_write(8, 0, 0);
    chk("cnt_clear", 32'(rd[RW-1:2+FW]), 32'(0));
    pi[8] = 1'b1;
    begin
      int n = 0;
      while (!er[8] && n < 10) begin tick(); n++; end
      chk("edge_wait", 32'(er[8]), 32'(1));
    end
    cfg_write(8, 0, 0);
    chk("cnt_coincident", 32'(rd[RW-1:2+FW]), 32'(0));
    tick();
    chk("cnt_coincident_hold", 32'(rd[RW-1:2+FW]), 32'(0));
    pi[8] = 1'b0;
    tick(4);

    // out-of-range write and read
    cfg_write(13, 5, 3);
    #1;
    chk("oor_read", 32'(rd), 32'(0));
    sel = 4'd0;
    #1;
    chk("oor_keep_flen0", 32'(rd[FW+1:2]), 32'(3));

    // reset in the middle of a filter count
    pi[0] = 1'b1;
    tick(3);
    rst = 1'b1;
    tick();
    chk("mrst_cin", 32'(cin), 32'(0));
    chk("mrst_edges", 32'({er, ef}), 32'(0));
    chk("mrst_t", 32'(pt), 32'({N{1'b1}}));
    chk("mrst_o", 32'(po), 32'(0));
    chk("mrst_rd", 32'(rd), 32'(0));
    rst = 1'b0;
    tick();
    chk("mrst_flen0", 32'(rd), 32'(0));
    tick(2);
    chk("mrst_resample", 32'(cin[0]), 32'(1));

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(3) == 0) pi[ch] = ~pi[ch];
        if ($urandom_range(3) == 0) cout[ch] = ~cout[ch];
        if ($urandom_range(7) == 0) coeb[ch] = ~coeb[ch];
      end
      we = ($urandom_range(15) == 0);
      sel = SW'($urandom_range(15));
      wd = {FW'($urandom_range(3)), 2'($urandom_range(3))};
      rst = ($urandom_range(299) == 0);
      #1;
      check_model();
      tick();
    end
    we = 1'b0; rst = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
